// File: rtl/alu_result_buffer.sv
// alu_result_buffer: show-ahead FIFO behind the 4-bit ALU.
// Each entry holds {opcode, result, dz}. The buffer flags dropped results
// with a sticky overflow bit and keeps a saturating count of accepted results.
//
// Handshake: a transfer happens on a rising edge when valid && ready are both
// high. in_ready is registered and equals !full. It stays low for the whole
// cycle while the buffer is full, even if a pop happens in that same cycle.
// out_* is registered and stays stable while out_valid && !out_ready.
module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [1:0]                 in_opcode,
    input  logic [DW-1:0]              in_result,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW-1:0]              out_result,
    output logic [1:0]                 out_opcode,
    output logic                       out_dz,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic [15:0]                accepted
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = DW + 3;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [EW-1:0] head_q, head_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   accepted_q, accepted_d;

    logic          push, pop, drop, in_dz;
    logic [EW-1:0] in_entry, next_head;

    // Next-state logic for the pointers, occupancy, head register and status.
    always_comb begin
        push       = in_valid && in_ready_q;
        drop       = in_valid && !in_ready_q;
        pop        = out_valid_q && out_ready;
        // A divide returns quotient+1 (1..16), so a zero divide result means the divisor was zero.
        in_dz      = (in_opcode == 2'b11) && (in_result == '0);
        in_entry   = {in_opcode, in_result, in_dz};

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        accepted_d = accepted_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);

        // The new head comes straight from the input when it lands on the slot we read next.
        if (push && (wr_ptr_q == rd_ptr_d)) next_head = in_entry;
        else                                next_head = mem_q[rd_ptr_d];

        // When the buffer goes empty the head register keeps its last value.
        head_d      = (count_d != '0) ? next_head : head_q;
        out_valid_d = (count_d != '0);
        in_ready_d  = (count_d != CW'(DEPTH));

        // A drop takes priority over a clear in the same cycle.
        if (drop)           overflow_d = 1'b1;
        else if (clear_ovf) overflow_d = 1'b0;

        if (push && (accepted_q != 16'hFFFF)) accepted_d = accepted_q + 16'd1;
    end

    // Control and status registers; reset discards all entries at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
            accepted_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
            accepted_q  <= accepted_d;
        end
    end

    // Entry storage; the contents are don't-care until written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_opcode = head_q[EW-1 -: 2];
    assign out_result = head_q[DW:1];
    assign out_dz     = head_q[0];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign accepted   = accepted_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed testbench for alu_result_buffer (DEPTH=4, DW=8).
module tb_alu_result_buffer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [1:0]  in_opcode;
    logic [7:0]  in_result;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_result;
    logic [1:0]  out_opcode;
    logic        out_dz;
    logic [2:0]  count;
    logic        overflow;
    logic        clear_ovf;
    logic [15:0] accepted;

    int errors = 0;
    int checks = 0;
    int acc_exp = 0;

    alu_result_buffer #(.DEPTH(4), .DW(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_dz     (out_dz),
        .count      (count),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .accepted   (accepted)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Checking task
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] res,
                         input logic rdy, input logic clr);
        in_valid  = v;
        in_opcode = op;
        in_result = res;
        out_ready = rdy;
        clear_ovf = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [1:0] op,
                              input logic [7:0] res, input logic dz);
        check({tag, "_valid"},  32'(out_valid),  32'd1);
        check({tag, "_result"}, 32'(out_result), 32'(res));
        check({tag, "_opcode"}, 32'(out_opcode), 32'(op));
        check({tag, "_dz"},     32'(out_dz),     32'(dz));
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        check("rst_count",    32'(count),      32'd0);
        check("rst_valid",    32'(out_valid),  32'd0);
        check("rst_in_ready", 32'(in_ready),   32'd1);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_accepted", 32'(accepted),   32'd0);
        check("rst_result",   32'(out_result), 32'd0);
        check("rst_opcode",   32'(out_opcode), 32'd0);
        check("rst_dz",       32'(out_dz),     32'd0);
        rst_n = 1'b1;
        step();

        // Single push with consumer ready: visible one cycle later, then drained
        drive(1'b1, 2'b00, 8'h09, 1'b1, 1'b0);
        step(); acc_exp++;
        check_head("t1_head", 2'b00, 8'h09, 1'b0);
        check("t1_count1", 32'(count), 32'd1);
        drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        step();
        check("t1_valid0",   32'(out_valid), 32'd0);
        check("t1_count0",   32'(count),     32'd0);
        check("t1_accepted", 32'(accepted),  32'd1);
        check("t1_hold",     32'(out_result), 32'h09);

        // Divide-by-zero tagging
        drive(1'b1, 2'b11, 8'h00, 1'b0, 1'b0);
        step(); acc_exp++;
        drive(1'b1, 2'b11, 8'h04, 1'b0, 1'b0);
        step(); acc_exp++;
        check_head("t2_head0", 2'b11, 8'h00, 1'b1);
        check("t2_count2", 32'(count), 32'd2);
        drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        step();
        check_head("t2_head1", 2'b11, 8'h04, 1'b0);
        check("t2_count1", 32'(count), 32'd1);
        step();
        check("t2_count0", 32'(count), 32'd0);
        check("t2_accepted", 32'(accepted), 32'(acc_exp));

        // Fill to full, drop the fifth, sticky overflow with set-wins clear
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b01, 8'hA0 + 8'(i), 1'b0, 1'b0);
            step();
            if (i < 4) acc_exp++;
            if (i == 3) begin
                check("t3_in_ready0", 32'(in_ready), 32'd0);
                check("t3_full_count", 32'(count), 32'd4);
                check("t3_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_count", 32'(count), 32'd4);
        check("t3_accepted", 32'(accepted), 32'(acc_exp));
        drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
        step();
        check("t4_clear", 32'(overflow), 32'd0);
        drive(1'b1, 2'b10, 8'h55, 1'b0, 1'b1);
        step();
        check("t4_set_wins", 32'(overflow), 32'd1);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b1);
        step();
        check("t4_clear2", 32'(overflow), 32'd0);
        check("t4_acc_kept", 32'(accepted), 32'(acc_exp));
        for (int i = 0; i < 4; i++) begin
            check_head("t3_pop", 2'b01, 8'hA0 + 8'(i), 1'b0);
            drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
            step();
            if (i == 0) check("t3_ready_after_pop", 32'(in_ready), 32'd1);
        end
        check("t3_drained", 32'(count), 32'd0);

        // Streaming at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 2'b01, 8'h10 + 8'(i), 1'b0, 1'b0);
            step(); acc_exp++;
        end
        for (int i = 0; i < 10; i++) begin
            check_head("t5_head", 2'b01, 8'h10 + 8'(i), 1'b0);
            check("t5_count", 32'(count), 32'd2);
            drive(1'b1, 2'b01, 8'h12 + 8'(i), 1'b1, 1'b0);
            step(); acc_exp++;
        end
        check_head("t5_tail0", 2'b01, 8'h1A, 1'b0);
        drive(1'b0, 2'b00, 8'h00, 1'b1, 1'b0);
        step();
        check_head("t5_tail1", 2'b01, 8'h1B, 1'b0);
        step();
        check("t5_empty", 32'(count), 32'd0);
        check("t5_accepted", 32'(accepted), 32'(acc_exp));

        // Asynchronous reset mid-stream at count=3
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'b10, 8'h30 + 8'(i), 1'b0, 1'b0);
            step();
        end
        check("t6_count3", 32'(count), 32'd3);
        drive(1'b0, 2'b00, 8'h00, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_accepted", 32'(accepted), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 8'hFE, 1'b0, 1'b0);
        step();
        check_head("t6_head", 2'b01, 8'hFE, 1'b0);
        check("t6_count1", 32'(count), 32'd1);
        check("t6_accepted1", 32'(accepted), 32'd1);

        // Final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Downstream stage of the 4-bit ALU: captures each 8-bit ALU result with the opcode that produced it into a small FIFO and presents it to the consumer over a valid/ready handshake. It decouples the combinational ALU, which produces a result every cycle, from a consumer that may stall. It also tags divide-by-zero results, flags dropped results, and counts accepted results.

## Interface

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, minimum 2.
- DW, 8, result width; matches the ALU output byte.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, an ALU result is presented this cycle.
- in_opcode, input, 2, opcode applied to the ALU for this result.
- in_result, input, DW, ALU output byte.
- in_ready, output, 1, buffer can accept; equals !full.
- out_valid, output, 1, the head entry is valid.
- out_ready, input, 1, consumer accepts the head entry.
- out_result, output, DW, result at the head entry.
- out_opcode, output, 2, opcode at the head entry.
- out_dz, output, 1, divide-by-zero tag at the head entry.
- count, output, $clog2(DEPTH+1), number of occupied entries.
- overflow, output, 1, sticky flag; a result was dropped.
- clear_ovf, input, 1, synchronous clear of overflow.
- accepted, output, 16, saturating count of pushed entries.

## Operation

- Push happens when in_valid && in_ready. The entry stored is {in_opcode, in_result, dz}.
- dz = (in_opcode == 2'b11) && (in_result == 0). For a nonzero divisor the divide result is quotient+1, which lies in 1..16, so a zero result means the divisor was zero.
- Drop happens when in_valid && !in_ready. Nothing is stored and overflow is set the next cycle.
- Pop happens when out_valid && out_ready. The read pointer advances.
- Push and pop in the same cycle are allowed whenever not full. count is unchanged and both pointers advance.
- When full, in_ready is 0 even if a pop occurs that cycle. There is no same-cycle bypass into a full FIFO.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is derived from count, not from pointer comparison.
- out_* always shows the head entry (show-ahead). When count == 0, out_valid = 0 and the out_* data is don't-care, but it holds its last value.
- overflow:
  - Set by a drop; cleared by clear_ovf.
  - If clear_ovf and a drop occur in the same cycle, set wins.
- accepted:
  - Increments by 1 on each push and saturates at 16'hFFFF.
  - Not cleared by clear_ovf.
- Results are stored bit-exact. Subtraction wrap-around is preserved (3−5 arrives as 8'hFE). No sign interpretation is applied.

## Timing

- Reset (rst_n low, asynchronous):
  - count = 0, out_valid = 0, in_ready = 1, overflow = 0, accepted = 0.
  - out_result = 0, out_opcode = 0, out_dz = 0, pointers = 0.
- Reset during operation discards all entries immediately. Outputs take their reset values without waiting for a clock edge.
- Latency: a push into an empty buffer at edge N gives out_valid = 1 with that entry's data after edge N, i.e. one cycle.
- out_valid, out_result, out_opcode and out_dz are stable while out_valid && !out_ready.
- in_ready and count update one cycle after the push or pop that changes them. in_ready is a registered function of count.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full-to-not-full: a pop at edge N with count == DEPTH raises in_ready after edge N.

## Test plan

- Reset, then push {op=00, 8'h09} with out_ready=1 -> out_valid=1 for one cycle with out_result=8'h09, out_opcode=00, out_dz=0; then count=0; accepted=1.
- Push {11, 8'h00}, then {11, 8'h04}, with out_ready=0 -> head shows out_dz=1; after a pop the head shows 8'h04 with out_dz=1 low (dz=0); count goes 2 then 1.
- With out_ready=0, push DEPTH+1 results in 5 consecutive cycles -> in_ready=0 after the 4th push, the 5th is dropped, overflow=1, count=4; pop order is the first 4 values.
- Assert clear_ovf in the same cycle as a drop -> overflow stays 1; clear_ovf alone on the next cycle -> overflow=0.
- Continuous push and pop with both valid and ready high for 10 cycles, starting at count=2 -> count stays 2 and output order matches input order across pointer wrap.
- Assert rst_n low mid-stream at count=3 -> out_valid=0, count=0, accepted=0 immediately; the first push after release appears at the head.
